// File: rtl/rs_pkg.sv
// Shared definitions for the ALU reservation station: op codes and datapath widths.
package rs_pkg;
  localparam int RS_OP_WIDTH = 4;
  localparam int RS_DATA_W   = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_EQ  = 4'd8,
    OP_NE  = 4'd9,
    OP_LT  = 4'd10,
    OP_LTU = 4'd11,
    OP_GE  = 4'd12,
    OP_GEU = 4'd13
  } rs_op_e;
endpackage

// File: rtl/rs_alu.sv
// Combinational integer ALU for the reservation station exec stage.
module rs_alu
  import rs_pkg::*;
#(
  parameter int OP_W = RS_OP_WIDTH
) (
  input  logic [OP_W-1:0]      i_op,
  input  logic [RS_DATA_W-1:0] i_v1,
  input  logic [RS_DATA_W-1:0] i_v2,
  output logic [RS_DATA_W-1:0] o_res
);
  logic signed [RS_DATA_W-1:0] w_s1;
  logic signed [RS_DATA_W-1:0] w_s2;
  logic [4:0]                  w_sh;
  logic [31:0]                 w_op;

  assign w_s1 = i_v1;
  assign w_s2 = i_v2;
  assign w_sh = i_v2[4:0];
  assign w_op = 32'(i_op);

  // Unlisted codes (including wide op codes above 13) produce zero.
  always_comb begin
    o_res = '0;
    case (w_op)
      32'(OP_ADD): o_res = i_v1 + i_v2;
      32'(OP_SUB): o_res = i_v1 - i_v2;
      32'(OP_XOR): o_res = i_v1 ^ i_v2;
      32'(OP_OR):  o_res = i_v1 | i_v2;
      32'(OP_AND): o_res = i_v1 & i_v2;
      32'(OP_SLL): o_res = i_v1 << w_sh;
      32'(OP_SRL): o_res = i_v1 >> w_sh;
      32'(OP_SRA): o_res = w_s1 >>> w_sh;
      32'(OP_EQ):  o_res = RS_DATA_W'(i_v1 == i_v2);
      32'(OP_NE):  o_res = RS_DATA_W'(i_v1 != i_v2);
      32'(OP_LT):  o_res = RS_DATA_W'(w_s1 < w_s2);
      32'(OP_LTU): o_res = RS_DATA_W'(i_v1 < i_v2);
      32'(OP_GE):  o_res = RS_DATA_W'(w_s1 >= w_s2);
      32'(OP_GEU): o_res = RS_DATA_W'(i_v1 >= i_v2);
      default:     o_res = '0;
    endcase
  end
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: renamed ops wait for operands, oldest ready entry issues
// through a one-deep exec stage into a valid/ready result register.
module alu_reservation_station
  import rs_pkg::RS_DATA_W;
#(
  parameter int RS_OP_WIDTH = 4,
  parameter int RS_DEPTH    = 16,
  parameter int ROB_WIDTH   = 4,
  parameter int NUM_WAKEUP  = 2,
  parameter int FULL_MARGIN = 1
) (
  input  logic                             clockIn,
  input  logic                             resetIn,
  input  logic                             readyIn,
  input  logic                             flushIn,
  input  logic                             addValid,
  input  logic [RS_OP_WIDTH-1:0]           addOp,
  input  logic [ROB_WIDTH-1:0]             addRobIndex,
  input  logic [31:0]                      addVal1,
  input  logic [31:0]                      addVal2,
  input  logic                             addHasDep1,
  input  logic                             addHasDep2,
  input  logic [ROB_WIDTH-1:0]             addConstrt1,
  input  logic [ROB_WIDTH-1:0]             addConstrt2,
  output logic                             full,
  output logic [$clog2(RS_DEPTH+1)-1:0]    count,
  input  logic [NUM_WAKEUP-1:0]            wakeupValid,
  input  logic [NUM_WAKEUP*ROB_WIDTH-1:0]  wakeupRobIndex,
  input  logic [NUM_WAKEUP*32-1:0]         wakeupVal,
  output logic                             resultValid,
  input  logic                             resultReady,
  output logic [ROB_WIDTH-1:0]             resultRobIndex,
  output logic [31:0]                      resultVal
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  // Internal result has priority, then channel 0 upward; returns {hit, value}.
  function automatic logic [RS_DATA_W:0] f_wake(
    input logic [ROB_WIDTH-1:0]            c,
    input logic                            int_v,
    input logic [ROB_WIDTH-1:0]            int_tag,
    input logic [RS_DATA_W-1:0]            int_val,
    input logic [NUM_WAKEUP-1:0]           wv,
    input logic [NUM_WAKEUP*ROB_WIDTH-1:0] wt,
    input logic [NUM_WAKEUP*32-1:0]        wd
  );
    logic [RS_DATA_W:0] r;
    r = '0;
    for (int k = NUM_WAKEUP-1; k >= 0; k--)
      if (wv[k] && wt[k*ROB_WIDTH +: ROB_WIDTH] == c) r = {1'b1, wd[k*32 +: 32]};
    if (int_v && int_tag == c) r = {1'b1, int_val};
    return r;
  endfunction

  logic [RS_DEPTH-1:0]    r_vld, r_dep1, r_dep2;
  logic [RS_OP_WIDTH-1:0] r_op   [RS_DEPTH];
  logic [ROB_WIDTH-1:0]   r_tag  [RS_DEPTH];
  logic [ROB_WIDTH-1:0]   r_c1   [RS_DEPTH];
  logic [ROB_WIDTH-1:0]   r_c2   [RS_DEPTH];
  logic [RS_DATA_W-1:0]   r_v1   [RS_DEPTH];
  logic [RS_DATA_W-1:0]   r_v2   [RS_DEPTH];
  logic [RS_DEPTH-1:0]    r_older[RS_DEPTH];
  logic [CNT_W-1:0]       r_count;

  logic                   r_vld_p1, r_vld_p2;
  logic [RS_OP_WIDTH-1:0] r_op_p1;
  logic [RS_DATA_W-1:0]   r_v1_p1, r_v2_p1, r_val_p2;
  logic [ROB_WIDTH-1:0]   r_tag_p1, r_tag_p2;

  logic [RS_DEPTH-1:0]    w_rdy, w_sel_oh;
  logic [RS_DEPTH-1:0]    w_col  [RS_DEPTH];
  logic [RS_DATA_W:0]     w_wk1  [RS_DEPTH];
  logic [RS_DATA_W:0]     w_wk2  [RS_DEPTH];
  logic [RS_DATA_W:0]     w_addwk1, w_addwk2;
  logic [IDX_W-1:0]       w_sel_idx, w_free_idx;
  logic                   w_any_free, w_add, w_issue, w_ex_move, w_int_fire;
  logic [RS_DATA_W-1:0]   w_alu_res;

  assign w_rdy      = r_vld & ~r_dep1 & ~r_dep2;
  assign w_ex_move  = r_vld_p1 & (~r_vld_p2 | resultReady);
  assign w_int_fire = readyIn & w_ex_move;
  assign w_add      = readyIn & ~flushIn & addValid & w_any_free;
  assign w_issue    = readyIn & ~flushIn & (|w_rdy) & (~r_vld_p1 | w_ex_move);

  assign w_addwk1 = f_wake(addConstrt1, w_int_fire, r_tag_p1, w_alu_res,
                           wakeupValid, wakeupRobIndex, wakeupVal);
  assign w_addwk2 = f_wake(addConstrt2, w_int_fire, r_tag_p1, w_alu_res,
                           wakeupValid, wakeupRobIndex, wakeupVal);

  // r_older[j][i] set means entry j was allocated before entry i.
  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_ent
    for (genvar gj = 0; gj < RS_DEPTH; gj++) begin : g_col
      assign w_col[gi][gj] = r_older[gj][gi];
    end
    assign w_sel_oh[gi] = w_rdy[gi] & ~|(w_rdy & w_col[gi]);
    assign w_wk1[gi] = f_wake(r_c1[gi], w_int_fire, r_tag_p1, w_alu_res,
                              wakeupValid, wakeupRobIndex, wakeupVal);
    assign w_wk2[gi] = f_wake(r_c2[gi], w_int_fire, r_tag_p1, w_alu_res,
                              wakeupValid, wakeupRobIndex, wakeupVal);
  end

  always_comb begin
    w_sel_idx  = '0;
    w_free_idx = '0;
    w_any_free = 1'b0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (w_sel_oh[i]) w_sel_idx = IDX_W'(i);
      if (!r_vld[i]) begin
        w_free_idx = IDX_W'(i);
        w_any_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      r_vld    <= '0;
      r_dep1   <= '0;
      r_dep2   <= '0;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_tag_p2 <= '0;
      r_val_p2 <= '0;
    end else if (flushIn) begin
      r_vld    <= '0;
      r_count  <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (readyIn) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (w_wk1[i][RS_DATA_W]) r_dep1[i] <= 1'b0;
        if (w_wk2[i][RS_DATA_W]) r_dep2[i] <= 1'b0;
      end
      if (w_issue) r_vld[w_sel_idx] <= 1'b0;
      if (w_add) begin
        r_vld[w_free_idx]  <= 1'b1;
        r_dep1[w_free_idx] <= addHasDep1 & ~w_addwk1[RS_DATA_W];
        r_dep2[w_free_idx] <= addHasDep2 & ~w_addwk2[RS_DATA_W];
      end
      r_count <= r_count + CNT_W'(w_add) - CNT_W'(w_issue);
      // exec stage (p1)
      if (w_issue)        r_vld_p1 <= 1'b1;
      else if (w_ex_move) r_vld_p1 <= 1'b0;
      // result stage (p2)
      if (w_ex_move) begin
        r_vld_p2 <= 1'b1;
        r_tag_p2 <= r_tag_p1;
        r_val_p2 <= w_alu_res;
      end else if (resultReady) begin
        r_vld_p2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clockIn) begin
    if (readyIn) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_dep1[i] && w_wk1[i][RS_DATA_W]) r_v1[i] <= w_wk1[i][RS_DATA_W-1:0];
        if (r_dep2[i] && w_wk2[i][RS_DATA_W]) r_v2[i] <= w_wk2[i][RS_DATA_W-1:0];
      end
      if (w_add) begin
        r_op[w_free_idx]  <= addOp;
        r_tag[w_free_idx] <= addRobIndex;
        r_c1[w_free_idx]  <= addConstrt1;
        r_c2[w_free_idx]  <= addConstrt2;
        r_v1[w_free_idx]  <= (addHasDep1 && w_addwk1[RS_DATA_W]) ? w_addwk1[RS_DATA_W-1:0] : addVal1;
        r_v2[w_free_idx]  <= (addHasDep2 && w_addwk2[RS_DATA_W]) ? w_addwk2[RS_DATA_W-1:0] : addVal2;
        for (int j = 0; j < RS_DEPTH; j++) r_older[j][w_free_idx] <= 1'b1;
        r_older[w_free_idx] <= '0;
      end
      if (w_issue) begin
        r_op_p1  <= r_op[w_sel_idx];
        r_v1_p1  <= r_v1[w_sel_idx];
        r_v2_p1  <= r_v2[w_sel_idx];
        r_tag_p1 <= r_tag[w_sel_idx];
      end
    end
  end

  rs_alu #(.OP_W(RS_OP_WIDTH)) u_alu (
    .i_op (r_op_p1),
    .i_v1 (r_v1_p1),
    .i_v2 (r_v2_p1),
    .o_res(w_alu_res)
  );

  assign resultValid    = r_vld_p2;
  assign resultRobIndex = r_tag_p2;
  assign resultVal      = r_val_p2;
  assign count          = r_count;
  assign full           = (r_count >= CNT_W'(RS_DEPTH - FULL_MARGIN));
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with hand-computed results.
module tb_alu_reservation_station;
  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, flushIn, addValid;
  logic [3:0]  addOp, addRobIndex, addConstrt1, addConstrt2;
  logic [31:0] addVal1, addVal2;
  logic        addHasDep1, addHasDep2;
  logic        full;
  logic [4:0]  count;
  logic [1:0]  wakeupValid;
  logic [7:0]  wakeupRobIndex;
  logic [63:0] wakeupVal;
  logic        resultValid, resultReady;
  logic [3:0]  resultRobIndex;
  logic [31:0] resultVal;

  int n_checks = 0;
  int n_errors = 0;
  logic [35:0] q_res[$];

  logic [3:0]  t_op [15] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14};
  logic [31:0] t_v1 [15] = '{32'd3, 32'd3, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd1, 32'h80000000,
                             32'h80000000, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7};
  logic [31:0] t_v2 [15] = '{32'd5, 32'd5, 32'hFF00, 32'hFF00, 32'hFF00, 32'd36, 32'd4, 32'd4,
                             32'd5, 32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd7};
  logic [31:0] t_exp[15] = '{32'd8, 32'hFFFFFFFE, 32'h0FF0, 32'hFFF0, 32'hF000, 32'h10,
                             32'h08000000, 32'hF8000000, 32'd1, 32'd0, 32'd1, 32'd0,
                             32'd0, 32'd1, 32'd0};

  always #5 clockIn = ~clockIn;

  alu_reservation_station #(
    .RS_OP_WIDTH(4), .RS_DEPTH(16), .ROB_WIDTH(4), .NUM_WAKEUP(2), .FULL_MARGIN(1)
  ) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
    .addValid(addValid), .addOp(addOp), .addRobIndex(addRobIndex),
    .addVal1(addVal1), .addVal2(addVal2), .addHasDep1(addHasDep1), .addHasDep2(addHasDep2),
    .addConstrt1(addConstrt1), .addConstrt2(addConstrt2), .full(full), .count(count),
    .wakeupValid(wakeupValid), .wakeupRobIndex(wakeupRobIndex), .wakeupVal(wakeupVal),
    .resultValid(resultValid), .resultReady(resultReady),
    .resultRobIndex(resultRobIndex), .resultVal(resultVal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic add_op(input logic [3:0] op, input logic [3:0] tag, input logic [31:0] v1,
                        input logic [31:0] v2, input logic d1, input logic [3:0] c1,
                        input logic d2, input logic [3:0] c2);
    addValid = 1'b1; addOp = op; addRobIndex = tag; addVal1 = v1; addVal2 = v2;
    addHasDep1 = d1; addConstrt1 = c1; addHasDep2 = d2; addConstrt2 = c2;
    tick();
    addValid = 1'b0; addHasDep1 = 1'b0; addHasDep2 = 1'b0;
  endtask

  task automatic wake(input int ch, input logic [3:0] tag, input logic [31:0] val);
    wakeupValid = '0;
    wakeupValid[ch] = 1'b1;
    wakeupRobIndex[ch*4 +: 4] = tag;
    wakeupVal[ch*32 +: 32] = val;
  endtask

  task automatic wait_q(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (q_res.size() < n && cyc < 300) begin
      tick();
      cyc++;
    end
    check(tag, 64'(q_res.size()), 64'(n));
  endtask

  always @(negedge clockIn)
    if (resetIn && resultValid && resultReady) q_res.push_back({resultRobIndex, resultVal});

  always @(negedge clockIn)
    if (resetIn && addValid && !flushIn && count == 5'd16) check("illegal_add", 1, 0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    resetIn = 1'b0; readyIn = 1'b1; flushIn = 1'b0; addValid = 1'b0; addOp = '0;
    addRobIndex = '0; addVal1 = '0; addVal2 = '0; addHasDep1 = 1'b0; addHasDep2 = 1'b0;
    addConstrt1 = '0; addConstrt2 = '0; wakeupValid = '0; wakeupRobIndex = '0;
    wakeupVal = '0; resultReady = 1'b1;
    tick(); tick();
    check("rst_rv", resultValid, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_tag", resultRobIndex, 0);
    check("rst_val", resultVal, 0);
    resetIn = 1'b1;
    tick();

    // Minimum latency ADD
    add_op(0, 3, 5, 7, 0, 0, 0, 0);
    check("t1_count", count, 1);
    tick();
    check("t1_exec_rv", resultValid, 0);
    check("t1_count_iss", count, 0);
    tick();
    check("t1_rv", resultValid, 1);
    check("t1_tag", resultRobIndex, 3);
    check("t1_val", resultVal, 12);
    tick();

    // External wakeup on channel 1
    add_op(1, 1, 0, 8, 1, 9, 0, 0);
    tick(); tick(); tick();
    check("t2_wait_rv", resultValid, 0);
    check("t2_wait_count", count, 1);
    wake(1, 9, 20);
    tick();
    wakeupValid = '0;
    tick();
    check("t2_sel_rv", resultValid, 0);
    tick();
    check("t2_rv", resultValid, 1);
    check("t2_tag", resultRobIndex, 1);
    check("t2_val", resultVal, 12);
    tick();

    // Internal wakeup chain
    q_res.delete();
    add_op(0, 2, 10, 3, 0, 0, 0, 0);
    add_op(0, 4, 0, 100, 1, 2, 0, 0);
    wait_q(2, "t3_n");
    check("t3_r0", q_res[0], {4'd2, 32'd13});
    check("t3_r1", q_res[1], {4'd4, 32'd113});

    // Add-time merge on operand 2
    q_res.delete();
    wake(0, 11, 40);
    add_op(0, 5, 2, 0, 0, 0, 1, 11);
    wakeupValid = '0;
    wait_q(1, "merge_n");
    check("merge_r", q_res[0], {4'd5, 32'd42});

    // ALU op table, issued in allocation order
    q_res.delete();
    for (int i = 0; i < 15; i++) add_op(t_op[i], 4'(i), t_v1[i], t_v2[i], 0, 0, 0, 0);
    wait_q(15, "alu_n");
    for (int i = 0; i < 15; i++) check($sformatf("alu_op%0d", i), q_res[i], {4'(i), t_exp[i]});

    // readyIn freeze
    q_res.delete();
    add_op(0, 6, 20, 22, 0, 0, 0, 0);
    readyIn = 1'b0;
    tick();
    addValid = 1'b1; addRobIndex = 4'd7;
    tick();
    addValid = 1'b0;
    tick();
    check("frz_count", count, 1);
    check("frz_rv", resultValid, 0);
    readyIn = 1'b1;
    wait_q(1, "frz_n");
    check("frz_r", q_res[0], {4'd6, 32'd42});
    check("frz_count_end", count, 0);

    // Fill, full threshold and age ordering with out-of-index allocation
    q_res.delete();
    add_op(0, 0, 0, 1, 1, 13, 0, 0);
    add_op(0, 1, 0, 2, 1, 13, 0, 0);
    for (int i = 0; i < 12; i++) add_op(0, 4'(i+2), 0, 32'(10+i), 1, 15, 0, 0);
    check("fill_count14", count, 14);
    check("fill_full14", full, 0);
    add_op(0, 14, 0, 22, 1, 15, 0, 0);
    check("fill_count15", count, 15);
    check("fill_full15", full, 1);
    add_op(0, 15, 0, 23, 1, 15, 0, 0);
    check("fill_count16", count, 16);
    wake(0, 13, 1000);
    tick();
    wakeupValid = '0;
    wait_q(2, "blk_n");
    check("blk_r0", q_res[0], {4'd0, 32'd1001});
    check("blk_r1", q_res[1], {4'd1, 32'd1002});
    add_op(0, 0, 0, 50, 1, 15, 0, 0);
    add_op(0, 1, 0, 51, 1, 15, 0, 0);
    check("refill_count", count, 16);
    q_res.delete();
    wake(1, 15, 2000);
    tick();
    wakeupValid = '0;
    wait_q(16, "age_n");
    for (int k = 0; k < 14; k++) check($sformatf("age_%0d", k), q_res[k], {4'(k+2), 32'(2010+k)});
    check("age_14", q_res[14], {4'd0, 32'd2050});
    check("age_15", q_res[15], {4'd1, 32'd2051});

    // Back-pressure
    q_res.delete();
    resultReady = 1'b0;
    add_op(0, 4, 4, 0, 0, 0, 0, 0);
    tick(); tick();
    check("bp_first_rv", resultValid, 1);
    for (int i = 5; i < 8; i++) add_op(0, 4'(i), 32'(i), 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    check("bp_rv", resultValid, 1);
    check("bp_tag", resultRobIndex, 4);
    check("bp_val", resultVal, 4);
    check("bp_count", count, 2);
    resultReady = 1'b1;
    wait_q(4, "bp_n");
    for (int i = 0; i < 4; i++) check($sformatf("bp_r%0d", i), q_res[i], {4'(i+4), 32'(i+4)});
    check("bp_count_end", count, 0);

    // Flush with pending result and concurrent add
    q_res.delete();
    resultReady = 1'b0;
    add_op(0, 8, 8, 0, 0, 0, 0, 0);
    add_op(0, 9, 0, 1, 1, 12, 0, 0);
    tick();
    check("fl_pre_rv", resultValid, 1);
    flushIn = 1'b1;
    add_op(0, 10, 1, 1, 0, 0, 0, 0);
    flushIn = 1'b0;
    check("fl_rv", resultValid, 0);
    check("fl_count", count, 0);
    check("fl_full", full, 0);
    resultReady = 1'b1;
    wake(0, 12, 5);
    tick();
    wakeupValid = '0;
    repeat (6) tick();
    check("fl_none_issued", 64'(q_res.size()), 0);
    check("fl_rv_end", resultValid, 0);

    // Asynchronous reset mid-operation
    q_res.delete();
    add_op(0, 3, 1, 1, 0, 0, 0, 0);
    tick();
    resetIn = 1'b0;
    #2;
    check("ar_count", count, 0);
    check("ar_rv", resultValid, 0);
    tick();
    resetIn = 1'b1;
    repeat (4) tick();
    check("ar_none", 64'(q_res.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
